// File: rtl/lca_pkg.sv
// Shared types and width helpers for the linear-correspondence pair scanner.
package lca_pkg;

  localparam int unsigned SUBJ_W = 4;
  localparam int unsigned OBJ_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [SUBJ_W-1:0] subject;
    logic [OBJ_W-1:0]  object;
  } relation_entry_t;

  // Index width for a table of n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold the number of unordered pairs of n entries.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/lc_entry_table.sv
// Relation entry storage: one write port, two combinational read ports.
module lc_entry_table
  import lca_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IDX_W-1:0] widx,
  input  relation_entry_t wdata,
  input  logic [IDX_W-1:0] ridx_a,
  input  logic [IDX_W-1:0] ridx_b,
  output relation_entry_t rdata_a,
  output relation_entry_t rdata_b
);

  relation_entry_t mem [DEPTH];

  // Storage is left unreset; validity is tracked by the owner's entry count.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata_a = mem[ridx_a];
  assign rdata_b = mem[ridx_b];

endmodule

// File: rtl/lc_pair_scanner.sv
// Buffers relation entries and walks every unordered pair through an
// external combinational checker, streaming out the matching pairs.
module lc_pair_scanner
  import lca_pkg::*;
#(
  parameter int unsigned NUM_SUBJECTS = SUBJ_W,
  parameter int unsigned NUM_OBJECTS  = OBJ_W,
  parameter int unsigned MAX_ENTRIES  = 8,
  parameter int unsigned IDX_W        = idx_width(MAX_ENTRIES),
  parameter int unsigned CNT_W        = cnt_width(MAX_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NUM_SUBJECTS-1:0] load_subject,
  input  logic [NUM_OBJECTS-1:0]  load_object,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W:0]          entry_count,
  output logic [CNT_W-1:0]        match_count,
  output logic [NUM_SUBJECTS-1:0] chk_subject1,
  output logic [NUM_OBJECTS-1:0]  chk_object1,
  output logic [NUM_SUBJECTS-1:0] chk_subject2,
  output logic [NUM_OBJECTS-1:0]  chk_object2,
  input  logic                    chk_result,
  output logic                    pair_valid,
  input  logic                    pair_ready,
  output logic [IDX_W-1:0]        pair_idx1,
  output logic [IDX_W-1:0]        pair_idx2
);

  localparam int unsigned ECNT_W = IDX_W + 1;

  scan_state_t       state_q, state_d;
  logic [ECNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [IDX_W-1:0]  i_q, i_d, j_q, j_d;
  logic [IDX_W-1:0]  idx1_q, idx1_d, idx2_q, idx2_d;
  relation_entry_t   chk1_q, chk1_d, chk2_q, chk2_d;

  relation_entry_t   rd_a, rd_b, wdata;
  logic              load_fire;

  scan_state_t       adv_state;
  logic [IDX_W-1:0]  adv_i, adv_j;

  assign wdata     = '{subject: load_subject, object: load_object};
  assign load_fire = load_valid && load_ready;

  lc_entry_table #(
    .DEPTH (MAX_ENTRIES),
    .IDX_W (IDX_W)
  ) u_table (
    .clk     (clk),
    .we      (load_fire),
    .widx    (count_q[IDX_W-1:0]),
    .wdata   (wdata),
    .ridx_a  (i_q),
    .ridx_b  (j_q),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Pair advance: step j, else step i and restart j at i+1, else finish.
  always_comb begin
    adv_state = DONE;
    adv_i     = i_q;
    adv_j     = j_q;
    if ((ECNT_W'(j_q) + ECNT_W'(1)) < count_q) begin
      adv_j     = j_q + IDX_W'(1);
      adv_state = DRIVE;
    end else if ((ECNT_W'(i_q) + ECNT_W'(2)) < count_q) begin
      adv_i     = i_q + IDX_W'(1);
      adv_j     = i_q + IDX_W'(2);
      adv_state = DRIVE;
    end
  end

  // Next-state and datapath updates for the scan FSM.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    match_d = match_q;
    i_d     = i_q;
    j_d     = j_q;
    idx1_d  = idx1_q;
    idx2_d  = idx2_q;
    chk1_d  = chk1_q;
    chk2_d  = chk2_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (start) begin
          match_d = '0;
          i_d     = '0;
          j_d     = IDX_W'(1);
          state_d = (count_q < ECNT_W'(2)) ? DONE : DRIVE;
        end else if (load_fire) begin
          count_d = count_q + ECNT_W'(1);
        end
      end
      DRIVE: begin
        chk1_d  = rd_a;
        chk2_d  = rd_b;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        if (chk_result) begin
          match_d = match_q + CNT_W'(1);
          idx1_d  = i_q;
          idx2_d  = j_q;
          state_d = EMIT;
        end else begin
          i_d     = adv_i;
          j_d     = adv_j;
          state_d = adv_state;
        end
      end
      EMIT: begin
        if (pair_ready) begin
          i_d     = adv_i;
          j_d     = adv_j;
          state_d = adv_state;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      match_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      chk1_q  <= '0;
      chk2_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      match_q <= match_d;
      i_q     <= i_d;
      j_q     <= j_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      chk1_q  <= chk1_d;
      chk2_q  <= chk2_d;
    end
  end

  assign load_ready   = (state_q == IDLE) && !start && !clear &&
                        (count_q < ECNT_W'(MAX_ENTRIES));
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign pair_valid   = (state_q == EMIT);
  assign entry_count  = count_q;
  assign match_count  = match_q;
  assign pair_idx1    = idx1_q;
  assign pair_idx2    = idx2_q;
  assign chk_subject1 = chk1_q.subject;
  assign chk_object1  = chk1_q.object;
  assign chk_subject2 = chk2_q.subject;
  assign chk_object2  = chk2_q.object;

endmodule
